memory_interface: RTL and testbench
===================================

# memory_interface

Memory subsystem directly downstream of the CPU control unit. Holds MAR and MDR, owns the 2^ADDR_WIDTH-word main RAM, and carries out the multi-cycle reads and writes that the control unit requests with MD_read/MDRin and Write. It reports progress through mem_busy and mem_done so that the control unit can hold its current state until the access completes.

## Interface
- ADDR_WIDTH, 9, MAR width and RAM depth (512 words)
- DATA_WIDTH, 32, bus, MDR and RAM word width
- MEM_LATENCY, 2, clock edges from request to completion; legal range 1..15
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately
- BusMuxOut  in  DATA_WIDTH  datapath bus
- MARin  in  1  load MAR from BusMuxOut[ADDR_WIDTH-1:0]
- MDRin  in  1  load MDR; the source is the bus when MD_read=0, and a RAM read is started when MD_read=1
- MD_read  in  1  read qualifier for MDRin
- Write  in  1  start a write of MDR to RAM[MAR]
- MAR_q  out  ADDR_WIDTH  current MAR
- MDR_q  out  DATA_WIDTH  current MDR (feeds the bus mux MDRout input)
- mem_busy  out  1  registered; high while an access is in flight
- mem_done  out  1  registered; one-cycle pulse when an access completes
- mem_err  out  1  sticky protocol-error flag; cleared only by reset

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT. Latency counter is 4 bits wide.
- IDLE, read request (MDRin & MD_read):
  - snapshot addr_s <= MAR
  - cnt <= MEM_LATENCY-1
  - next state RD_WAIT
- IDLE, Write:
  - snapshot addr_s <= MAR and data_s <= MDR
  - cnt <= MEM_LATENCY-1
  - next state WR_WAIT
- Snapshots take the registered MAR/MDR values. A MARin or bus-MDRin asserted in the same cycle as a request updates the register, but the request uses the old value.
- IDLE, read and Write asserted together: the read is performed, the write is dropped, mem_err <= 1.
- IDLE, MDRin & !MD_read: MDR <= BusMuxOut. No access is started.
- RD_WAIT / WR_WAIT at each edge:
  - cnt != 0: cnt decrements.
  - cnt == 0, read: MDR <= RAM[addr_s].
  - cnt == 0, write: RAM[addr_s] <= data_s.
  - On completion: mem_done <= 1, next state IDLE.
- While busy:
  - MARin is accepted; MAR updates, and the access in flight still uses addr_s.
  - MDRin (either form) and Write are ignored and set mem_err <= 1.
  - MDR keeps its value until read completion.
- Upper bus bits above ADDR_WIDTH are ignored by MAR. There is no address wrap logic and no range check.
- RAM contents are not cleared by reset. The bench preloads RAM or fills it through writes.

## Timing
- Reset values, held while reset is high:
  - MAR_q = 0, MDR_q = 0
  - mem_busy = 0, mem_done = 0, mem_err = 0
  - state IDLE, cnt = 0
- Reset mid-access aborts the access: no RAM write, no MDR update, no mem_done.
- Request sampled at edge E0. mem_busy is high after E0 and stays high through edge E_MEM_LATENCY.
- Completion occurs at edge E_L (L = MEM_LATENCY):
  - the new MDR (read) or the RAM update (write) is visible after E_L;
  - mem_busy falls after E_L;
  - mem_done is high for exactly the cycle between E_L and E_L+1.
- Earliest next request: sampled at E_L+1. A request sampled at E_L is treated as a request while busy (ignored, mem_err set).
- L=1 gives a single-cycle busy window. Throughput is one access per L+1 cycles.
- mem_done and mem_busy are never high in the same cycle.

## Test plan
- Reset: assert reset with arbitrary inputs toggling -> all outputs 0. Deassert, then MARin with bus 0x0000_0203 -> MAR_q = 0x003.
- Write then read, L=2:
  - Step 1: MAR <= 0x05A, MDR <= 0xDEADBEEF via bus, Write -> mem_busy high 2 cycles, then mem_done 1 cycle.
  - Step 2: MDR <= 0 via bus, then MDRin & MD_read -> MDR_q = 0xDEADBEEF after 2 edges.
- MAR change in flight: RAM[0x05A]=0x1111_2222, RAM[0x0FF]=0x3333_4444. Read at 0x05A, then MARin 0x0FF one cycle later -> MDR_q = 0x1111_2222, MAR_q = 0x0FF, mem_err = 0.
- Request while busy: Write asserted during RD_WAIT -> write ignored, RAM[MAR] unchanged, mem_err = 1 and stays 1 until reset.
- Simultaneous read + Write in IDLE at 0x010, which holds 0xCAFE_0001 -> MDR_q = 0xCAFE_0001, RAM unchanged, mem_err = 1.
- Reset mid-write: Write of 0xAAAA_5555 to 0x020, which holds 0x0; reset pulsed one cycle later with L=3 -> mem_busy 0 immediately, mem_done never pulses, RAM[0x020] still 0x0. Repeat the write with L=1 -> busy for 1 cycle, RAM[0x020] = 0xAAAA_5555.

Source files
------------

// File: rtl/memory_interface.sv
// MAR/MDR holding registers plus main RAM, with a fixed-latency multi-cycle
// read/write sequencer that reports progress to the CPU control unit.
module memory_interface #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  MD_read,
    input  logic                  Write,
    output logic [ADDR_WIDTH-1:0] MAR_q,
    output logic [DATA_WIDTH-1:0] MDR_q,
    output logic                  mem_busy,
    output logic                  mem_done,
    output logic                  mem_err
);

    // state   | meaning
    // IDLE    | no access in flight, requests accepted
    // RD_WAIT | read in flight, MDR loads from RAM when cnt reaches 0
    // WR_WAIT | write in flight, RAM updates when cnt reaches 0
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic                  wr_en;

    // Reset asynchronously forces IDLE, so an aborted write never reaches RAM.
    assign wr_en = (state == WR_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clock) begin
        if (wr_en)
            ram[addr_s] <= data_s;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_s   <= '0;
            data_s   <= '0;
            MAR_q    <= '0;
            MDR_q    <= '0;
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            if (MARin)
                MAR_q <= BusMuxOut[ADDR_WIDTH-1:0];
            case (state)
                IDLE: begin
                    if (MDRin && !MD_read)
                        MDR_q <= BusMuxOut;
                    // Snapshots take the pre-edge MAR/MDR, not same-cycle loads.
                    if (MDRin && MD_read) begin
                        addr_s   <= MAR_q;
                        cnt      <= CNT_INIT;
                        mem_busy <= 1'b1;
                        state    <= RD_WAIT;
                        if (Write)
                            mem_err <= 1'b1;
                    end else if (Write) begin
                        addr_s   <= MAR_q;
                        data_s   <= MDR_q;
                        cnt      <= CNT_INIT;
                        mem_busy <= 1'b1;
                        state    <= WR_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (MDRin || Write)
                        mem_err <= 1'b1;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (state == RD_WAIT)
                            MDR_q <= ram[addr_s];
                        mem_busy <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: three instances (latency 1, 2, 3)
// share one stimulus; each scenario checks the instance it targets.
module tb_memory_interface;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] bus   = '0;
    logic        MARin = 1'b0;
    logic        MDRin = 1'b0;
    logic        MD_read = 1'b0;
    logic        Write = 1'b0;

    logic [8:0]  mar1, mar2, mar3;
    logic [31:0] mdr1, mdr2, mdr3;
    logic        busy1, busy2, busy3;
    logic        done1, done2, done3;
    logic        err1, err2, err3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .BusMuxOut(bus), .MARin(MARin), .MDRin(MDRin),
        .MD_read(MD_read), .Write(Write), .MAR_q(mar1), .MDR_q(mdr1),
        .mem_busy(busy1), .mem_done(done1), .mem_err(err1));

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .BusMuxOut(bus), .MARin(MARin), .MDRin(MDRin),
        .MD_read(MD_read), .Write(Write), .MAR_q(mar2), .MDR_q(mdr2),
        .mem_busy(busy2), .mem_done(done2), .mem_err(err2));

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .BusMuxOut(bus), .MARin(MARin), .MDRin(MDRin),
        .MD_read(MD_read), .Write(Write), .MAR_q(mar3), .MDR_q(mdr3),
        .mem_busy(busy3), .mem_done(done3), .mem_err(err3));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || busy2 || busy3) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy1 || busy2 || busy3) begin
            errors++;
            $display("FAIL wait_idle: busy still %b%b%b after %0d cycles, required 000", busy1, busy2, busy3, n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic load_mar(input logic [31:0] v);
        wait_idle();
        MARin = 1'b1; bus = v;
        tick();
        MARin = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        wait_idle();
        MDRin = 1'b1; MD_read = 1'b0; bus = v;
        tick();
        MDRin = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        load_mar(a);
        load_mdr(d);
        Write = 1'b1;
        tick();
        Write = 1'b0;
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a);
        load_mar(a);
        MDRin = 1'b1; MD_read = 1'b1;
        tick();
        MDRin = 1'b0; MD_read = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus = 32'h1234_5678 ^ (32'h0F0F_0F0F << i);
            MARin = i[0]; MDRin = i[1]; MD_read = ~i[0]; Write = i[0] ^ i[1];
            tick();
            checks++;
            if ({mar1, mar2, mar3, mdr1, mdr2, mdr3, busy1, busy2, busy3,
                 done1, done2, done3, err1, err2, err3} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d mar2=%h mdr2=%h busy=%b%b%b done=%b%b%b err=%b%b%b, required all 0",
                         i, mar2, mdr2, busy1, busy2, busy3, done1, done2, done3, err1, err2, err3);
            end
        end
        MARin = 1'b0; MDRin = 1'b0; MD_read = 1'b0; Write = 1'b0;
        reset = 1'b0;
        tick();
        MARin = 1'b1; bus = 32'h0000_0203;
        tick();
        MARin = 1'b0;
        checks++;
        if (mar2 !== 9'h003) begin
            errors++;
            $display("FAIL reset_mar_load: MAR_q=%h, required 003", mar2);
        end
    endtask

    task automatic test_write_read();
        logic [1:0] exp_busy [4];
        logic [1:0] exp_done [4];
        exp_busy[0] = 1; exp_busy[1] = 1; exp_busy[2] = 0; exp_busy[3] = 0;
        exp_done[0] = 0; exp_done[1] = 0; exp_done[2] = 1; exp_done[3] = 0;
        load_mar(32'h0000_005A);
        load_mdr(32'hDEAD_BEEF);
        Write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            Write = 1'b0;
            checks++;
            if (busy2 !== exp_busy[i][0] || done2 !== exp_done[i][0]) begin
                errors++;
                $display("FAIL write_timing: after edge %0d busy=%b done=%b, required busy=%b done=%b",
                         i, busy2, done2, exp_busy[i][0], exp_done[i][0]);
            end
        end
        load_mdr(32'h0000_0000);
        checks++;
        if (mdr2 !== 32'h0) begin
            errors++;
            $display("FAIL mdr_bus_load: MDR_q=%h, required 00000000", mdr2);
        end
        wait_idle();
        MDRin = 1'b1; MD_read = 1'b1;
        tick();
        MDRin = 1'b0; MD_read = 1'b0;
        checks++;
        if (mdr2 !== 32'h0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL read_e0: MDR_q=%h busy=%b, required 00000000 busy=1", mdr2, busy2);
        end
        tick();
        checks++;
        if (mdr2 !== 32'h0) begin
            errors++;
            $display("FAIL read_e1: MDR_q=%h, required 00000000", mdr2);
        end
        tick();
        checks++;
        if (mdr2 !== 32'hDEAD_BEEF || done2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL read_e2: MDR_q=%h done=%b busy=%b, required deadbeef done=1 busy=0", mdr2, done2, busy2);
        end
        wait_idle();
    endtask

    task automatic test_mar_change();
        do_write(32'h0000_005A, 32'h1111_2222);
        do_write(32'h0000_00FF, 32'h3333_4444);
        pulse_reset();
        load_mar(32'h0000_005A);
        MDRin = 1'b1; MD_read = 1'b1;
        tick();
        MDRin = 1'b0; MD_read = 1'b0;
        MARin = 1'b1; bus = 32'h0000_00FF;
        tick();
        MARin = 1'b0;
        wait_idle();
        checks++;
        if (mdr2 !== 32'h1111_2222 || mar2 !== 9'h0FF || err2 !== 1'b0) begin
            errors++;
            $display("FAIL mar_in_flight: MDR_q=%h MAR_q=%h err=%b, required 11112222 0ff 0", mdr2, mar2, err2);
        end
    endtask

    task automatic test_busy_request();
        load_mdr(32'h9999_9999);
        load_mar(32'h0000_005A);
        MDRin = 1'b1; MD_read = 1'b1;
        tick();
        MDRin = 1'b0; MD_read = 1'b0;
        Write = 1'b1;
        tick();
        Write = 1'b0;
        wait_idle();
        checks++;
        if (err2 !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_err: err=%b, required 1", err2);
        end
        do_read(32'h0000_005A);
        checks++;
        if (mdr2 !== 32'h1111_2222) begin
            errors++;
            $display("FAIL busy_write_ram: RAM[05a]=%h, required 11112222", mdr2);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (err2 !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err2);
        end
    endtask

    task automatic test_simultaneous();
        do_write(32'h0000_0010, 32'hCAFE_0001);
        pulse_reset();
        checks++;
        if (err2 !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: err=%b, required 0", err2);
        end
        load_mar(32'h0000_0010);
        load_mdr(32'h1234_5678);
        MDRin = 1'b1; MD_read = 1'b1; Write = 1'b1;
        tick();
        MDRin = 1'b0; MD_read = 1'b0; Write = 1'b0;
        wait_idle();
        checks++;
        if (mdr2 !== 32'hCAFE_0001 || err2 !== 1'b1) begin
            errors++;
            $display("FAIL rd_wr_both: MDR_q=%h err=%b, required cafe0001 1", mdr2, err2);
        end
        load_mdr(32'h0000_0000);
        do_read(32'h0000_0010);
        checks++;
        if (mdr2 !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL rd_wr_ram: RAM[010]=%h, required cafe0001", mdr2);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        do_write(32'h0000_0020, 32'h0000_0000);
        pulse_reset();
        load_mar(32'h0000_0020);
        load_mdr(32'hAAAA_5555);
        Write = 1'b1;
        tick();
        Write = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b, required 0 0", busy3, done3);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done3) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: mem_done pulses=%0d, required 0", done_seen);
        end
        load_mdr(32'hFFFF_FFFF);
        do_read(32'h0000_0020);
        checks++;
        if (mdr3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_write: RAM[020]=%h, required 00000000", mdr3);
        end
        load_mar(32'h0000_0020);
        load_mdr(32'hAAAA_5555);
        Write = 1'b1;
        tick();
        Write = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL l1_e0: busy=%b done=%b, required 1 0", busy1, done1);
        end
        tick();
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL l1_e1: busy=%b done=%b, required 0 1", busy1, done1);
        end
        wait_idle();
        load_mdr(32'h0000_0000);
        do_read(32'h0000_0020);
        checks++;
        if (mdr1 !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL l1_write: RAM[020]=%h, required aaaa5555", mdr1);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_write_read();
        test_mar_change();
        test_busy_request();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
